gray_codec: RTL and testbench

Parametrised, pipelined Gray-code engine for CDC pointer and encoder paths.
- Supports three per-transaction modes: binary->Gray, Gray->binary, and Gray increment.
- Uses a valid/ready handshake so it can sit between streaming producers and consumers.
- The Gray->binary XOR prefix chain is split across a configurable number of pipeline stages, so wide buses close timing.

---
 rtl/gray_codec_pkg.sv | 48 ++++
 rtl/gray_codec_stage.sv | 114 +++++++++++
 rtl/gray_codec.sv | 91 +++++++++
 tb/tb_gray_codec.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_codec_pkg.sv
//------------------------------------------------------------------------------
// gray_pkg : shared mode encodings and Gray-code helpers for the gray_codec block
// Revision : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package gray_pkg;

    localparam logic [1:0] MODE_B2G = 2'b00;
    localparam logic [1:0] MODE_G2B = 2'b01;
    localparam logic [1:0] MODE_INC = 2'b10;
    localparam logic [1:0] MODE_RSV = 2'b11;

    localparam int MAX_WIDTH = 32;

    // Operates at the maximum width; callers zero-extend and truncate back.
    function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g);
        logic [MAX_WIDTH-1:0] b;
        b = g;
        for (int k = MAX_WIDTH - 2; k >= 0; k--) begin
            b[k] = b[k+1] ^ g[k];
        end
        return b;
    endfunction

    // Bits of the XOR prefix chain resolved per pipeline stage: ceil(width/stages).
    function automatic int stage_bits(input int width, input int stages);
        return (width + stages - 1) / stages;
    endfunction

    function automatic int slice_hi(input int width, input int stages, input int idx);
        return width - 1 - idx * stage_bits(width, stages);
    endfunction

    function automatic int slice_lo(input int width, input int stages, input int idx);
        int lo;
        lo = width - (idx + 1) * stage_bits(width, stages);
        return (lo < 0) ? 0 : lo;
    endfunction

endpackage : gray_pkg

`default_nettype wire

// File: rtl/gray_codec_stage.sv
//------------------------------------------------------------------------------
// gray_codec_stage : one pipeline slot; resolves its slice of the Gray->binary
//                    prefix chain, first slot encodes, last slot increments.
// Revision : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module gray_codec_stage
    import gray_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int STAGES  = 2,
    parameter int IDX     = 0,
    parameter bit IS_LAST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv_i,
    input  logic             valid_i,
    input  logic [1:0]       mode_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             err_i,
    input  logic             wrap_i,
    output logic             valid_o,
    output logic [1:0]       mode_o,
    output logic [WIDTH-1:0] data_o,
    output logic             err_o,
    output logic             wrap_o
);

    localparam bit IS_FIRST = (IDX == 0);
    localparam int HI       = slice_hi(WIDTH, STAGES, IDX);
    localparam int LO       = slice_lo(WIDTH, STAGES, IDX);

    logic             valid_q, valid_d;
    logic [1:0]       mode_q,  mode_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic             err_q,   err_d;
    logic             wrap_q,  wrap_d;

    logic             w_decode;
    logic [WIDTH-1:0] w_pre;
    logic [WIDTH-1:0] w_res;
    logic [WIDTH-1:0] w_inc;
    logic             w_carry;

    assign w_decode = (mode_i == MODE_G2B) || (mode_i == MODE_INC);

    always_comb begin
        w_pre = data_i;
        if (IS_FIRST) begin
            if (mode_i == MODE_B2G) begin
                w_pre = WIDTH'(bin2gray(MAX_WIDTH'(data_i)));
            end else if (mode_i == MODE_RSV) begin
                w_pre = '0;
            end
        end
    end

    // Bits above the slice are already binary, bits below are still Gray.
    always_comb begin
        w_res   = w_pre;
        w_carry = 1'b0;
        if (w_decode) begin
            for (int j = WIDTH - 1; j >= 0; j--) begin
                if (j > HI) begin
                    w_carry = w_pre[j];
                end else if (j >= LO) begin
                    w_carry  = w_carry ^ w_pre[j];
                    w_res[j] = w_carry;
                end
            end
        end
    end

    always_comb begin
        valid_d = valid_i;
        mode_d  = mode_i;
        err_d   = err_i | (mode_i == MODE_RSV);
        data_d  = w_res;
        wrap_d  = wrap_i;
        w_inc   = w_res + WIDTH'(1);
        if (IS_LAST && (mode_i == MODE_INC)) begin
            wrap_d = &w_res;
            data_d = WIDTH'(bin2gray(MAX_WIDTH'(w_inc)));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            mode_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else if (adv_i) begin
            valid_q <= valid_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
            err_q   <= err_d;
            wrap_q  <= wrap_d;
        end
    end

    assign valid_o = valid_q;
    assign mode_o  = mode_q;
    assign data_o  = data_q;
    assign err_o   = err_q;
    assign wrap_o  = wrap_q;

endmodule : gray_codec_stage

`default_nettype wire

// File: rtl/gray_codec.sv
//------------------------------------------------------------------------------
// gray_codec : pipelined binary/Gray converter and Gray incrementer with a
//              valid/ready stream interface and fixed STAGES-cycle latency.
// Revision : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module gray_codec
    import gray_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [1:0]       i_mode,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [1:0]       o_mode,
    output logic [WIDTH-1:0] o_data,
    output logic             o_wrap,
    output logic             o_err
);

    logic             w_adv;
    logic             w_valid [STAGES];
    logic [1:0]       w_mode  [STAGES];
    logic [WIDTH-1:0] w_data  [STAGES];
    logic             w_err   [STAGES];
    logic             w_wrap  [STAGES];

    // The whole pipeline moves as one; bubbles are carried, never squeezed out.
    assign w_adv   = ~o_valid | o_ready;
    assign i_ready = w_adv;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic             w_valid_in;
        logic [1:0]       w_mode_in;
        logic [WIDTH-1:0] w_data_in;
        logic             w_err_in;
        logic             w_wrap_in;

        if (s == 0) begin : g_head
            assign w_valid_in = i_valid & w_adv;
            assign w_mode_in  = i_mode;
            assign w_data_in  = i_data;
            assign w_err_in   = 1'b0;
            assign w_wrap_in  = 1'b0;
        end else begin : g_body
            assign w_valid_in = w_valid[s-1];
            assign w_mode_in  = w_mode[s-1];
            assign w_data_in  = w_data[s-1];
            assign w_err_in   = w_err[s-1];
            assign w_wrap_in  = w_wrap[s-1];
        end

        gray_codec_stage #(
            .WIDTH   (WIDTH),
            .STAGES  (STAGES),
            .IDX     (s),
            .IS_LAST (s == STAGES - 1)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .adv_i   (w_adv),
            .valid_i (w_valid_in),
            .mode_i  (w_mode_in),
            .data_i  (w_data_in),
            .err_i   (w_err_in),
            .wrap_i  (w_wrap_in),
            .valid_o (w_valid[s]),
            .mode_o  (w_mode[s]),
            .data_o  (w_data[s]),
            .err_o   (w_err[s]),
            .wrap_o  (w_wrap[s])
        );
    end

    assign o_valid = w_valid[STAGES-1];
    assign o_mode  = w_mode[STAGES-1];
    assign o_data  = w_data[STAGES-1];
    assign o_err   = w_err[STAGES-1];
    assign o_wrap  = w_wrap[STAGES-1];

endmodule : gray_codec

`default_nettype wire

// File: tb/tb_gray_codec.sv
//------------------------------------------------------------------------------
// tb_gray_codec : directed self-checking bench for gray_codec (STAGES 1, 2, 4)
// Revision : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_gray_codec;

    localparam int N_SWEEP = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_valid;
    logic [1:0] i_mode;
    logic [3:0] i_data;
    logic       o_ready;

    logic       i_ready_2, o_valid_2, o_wrap_2, o_err_2;
    logic [1:0] o_mode_2;
    logic [3:0] o_data_2;
    logic       i_ready_1, o_valid_1, o_wrap_1, o_err_1;
    logic [1:0] o_mode_1;
    logic [3:0] o_data_1;
    logic       i_ready_4, o_valid_4, o_wrap_4, o_err_4;
    logic [1:0] o_mode_4;
    logic [3:0] o_data_4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    gray_codec #(.WIDTH(4), .STAGES(2)) u_dut2 (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready_2), .i_mode(i_mode),
        .i_data(i_data), .o_valid(o_valid_2), .o_ready(o_ready), .o_mode(o_mode_2),
        .o_data(o_data_2), .o_wrap(o_wrap_2), .o_err(o_err_2)
    );

    gray_codec #(.WIDTH(4), .STAGES(1)) u_dut1 (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready_1), .i_mode(i_mode),
        .i_data(i_data), .o_valid(o_valid_1), .o_ready(1'b1), .o_mode(o_mode_1),
        .o_data(o_data_1), .o_wrap(o_wrap_1), .o_err(o_err_1)
    );

    gray_codec #(.WIDTH(4), .STAGES(4)) u_dut4 (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready_4), .i_mode(i_mode),
        .i_data(i_data), .o_valid(o_valid_4), .o_ready(1'b1), .o_mode(o_mode_4),
        .o_data(o_data_4), .o_wrap(o_wrap_4), .o_err(o_err_4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] ref_g2b(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        for (int k = 2; k >= 0; k--) b[k] = b[k+1] ^ g[k];
        return b;
    endfunction

    task automatic ref_model(input logic [1:0] m, input logic [3:0] d,
                             output logic [3:0] r, output logic w, output logic e);
        logic [3:0] b;
        w = 1'b0;
        e = 1'b0;
        case (m)
            2'b00: r = d ^ (d >> 1);
            2'b01: r = ref_g2b(d);
            2'b10: begin
                b = ref_g2b(d);
                w = (b == 4'hF);
                b = b + 4'd1;
                r = b ^ (b >> 1);
            end
            default: begin
                r = 4'h0;
                e = 1'b1;
            end
        endcase
    endtask

    // One transaction into the STAGES=2 instance with o_ready held high.
    task automatic send_one(input string tag, input logic [1:0] m, input logic [3:0] d,
                            input logic [3:0] ed, input logic ew, input logic ee);
        check({tag, "_irdy"}, 32'(i_ready_2), 32'd1);
        i_valid = 1'b1;
        i_mode  = m;
        i_data  = d;
        tick();
        i_valid = 1'b0;
        check({tag, "_early"}, 32'(o_valid_2), 32'd0);
        tick();
        check({tag, "_valid"}, 32'(o_valid_2), 32'd1);
        check({tag, "_data"},  32'(o_data_2),  32'(ed));
        check({tag, "_mode"},  32'(o_mode_2),  32'(m));
        check({tag, "_wrap"},  32'(o_wrap_2),  32'(ew));
        check({tag, "_err"},   32'(o_err_2),   32'(ee));
        tick();
    endtask

    task automatic check_dut(input int s, input int c);
        int         k;
        logic       v, w, e, rdy;
        logic [1:0] om;
        logic [3:0] od, r;
        logic       ew, ee;
        k = c - s + 1;
        case (s)
            1:       begin v = o_valid_1; od = o_data_1; om = o_mode_1; w = o_wrap_1; e = o_err_1; rdy = i_ready_1; end
            2:       begin v = o_valid_2; od = o_data_2; om = o_mode_2; w = o_wrap_2; e = o_err_2; rdy = i_ready_2; end
            default: begin v = o_valid_4; od = o_data_4; om = o_mode_4; w = o_wrap_4; e = o_err_4; rdy = i_ready_4; end
        endcase
        check($sformatf("sweep_s%0d_c%0d_irdy", s, c), 32'(rdy), 32'd1);
        check($sformatf("sweep_s%0d_c%0d_valid", s, c), 32'(v), 32'((k >= 0) && (k < N_SWEEP)));
        if ((k >= 0) && (k < N_SWEEP)) begin
            ref_model(2'(k / 16), 4'(k % 16), r, ew, ee);
            check($sformatf("sweep_s%0d_k%0d_data", s, k), 32'(od), 32'(r));
            check($sformatf("sweep_s%0d_k%0d_mode", s, k), 32'(om), 32'(k / 16));
            check($sformatf("sweep_s%0d_k%0d_wrap", s, k), 32'(w),  32'(ew));
            check($sformatf("sweep_s%0d_k%0d_err",  s, k), 32'(e),  32'(ee));
        end
    endtask

    initial begin
        logic [3:0] bp_in  [5];
        logic [3:0] bp_exp [5];
        int         in_idx, out_idx;
        logic       was_hold, acc, take;
        logic [3:0] held;

        bp_in  = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
        bp_exp = '{4'd1, 4'd3, 4'd2, 4'd6, 4'd7};

        rst     = 1'b1;
        i_valid = 1'b0;
        i_mode  = 2'b00;
        i_data  = 4'h0;
        o_ready = 1'b1;
        #7;
        check("reset_valid", 32'(o_valid_2), 32'd0);
        check("reset_data",  32'(o_data_2),  32'd0);
        check("reset_mode",  32'(o_mode_2),  32'd0);
        check("reset_wrap",  32'(o_wrap_2),  32'd0);
        check("reset_err",   32'(o_err_2),   32'd0);
        check("reset_irdy",  32'(i_ready_2), 32'd1);
        #5;
        rst = 1'b0;
        tick();

        send_one("b2g_0101", 2'b00, 4'b0101, 4'b0111, 1'b0, 1'b0);
        send_one("g2b_0111", 2'b01, 4'b0111, 4'b0101, 1'b0, 1'b0);
        send_one("inc_wrap", 2'b10, 4'b1000, 4'b0000, 1'b1, 1'b0);
        send_one("inc_0001", 2'b10, 4'b0001, 4'b0011, 1'b0, 1'b0);
        send_one("rsv_F",    2'b11, 4'hF,    4'h0,    1'b0, 1'b1);

        // Back-to-back sweep through all three latencies at once.
        tick();
        tick();
        for (int c = 0; c < N_SWEEP + 4; c++) begin
            if (c < N_SWEEP) begin
                i_valid = 1'b1;
                i_mode  = 2'(c / 16);
                i_data  = 4'(c % 16);
            end else begin
                i_valid = 1'b0;
            end
            tick();
            check_dut(1, c);
            check_dut(2, c);
            check_dut(4, c);
        end
        i_valid = 1'b0;
        tick();

        // Backpressure: o_ready low for cycles 3..5 of the stream.
        in_idx   = 0;
        out_idx  = 0;
        was_hold = 1'b0;
        held     = 4'h0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            o_ready = !((cyc >= 3) && (cyc <= 5));
            i_valid = (in_idx < 5);
            i_mode  = 2'b00;
            i_data  = bp_in[(in_idx < 5) ? in_idx : 0];
            #1;
            if (was_hold) check($sformatf("bp_hold_c%0d", cyc), 32'(o_data_2), 32'(held));
            if (o_valid_2 && !o_ready) check($sformatf("bp_irdy_c%0d", cyc), 32'(i_ready_2), 32'd0);
            acc  = i_valid && i_ready_2;
            take = o_valid_2 && o_ready;
            if (take) begin
                if (out_idx < 5) check($sformatf("bp_data_%0d", out_idx), 32'(o_data_2), 32'(bp_exp[out_idx]));
                else             check("bp_extra_output", 32'(out_idx), 32'd4);
                out_idx++;
            end
            was_hold = o_valid_2 && !o_ready;
            held     = o_data_2;
            tick();
            if (acc) in_idx++;
        end
        i_valid = 1'b0;
        o_ready = 1'b1;
        check("bp_accepted", 32'(in_idx),  32'd5);
        check("bp_emitted",  32'(out_idx), 32'd5);

        // Asynchronous reset in the middle of a stream.
        for (int c = 0; c < 3; c++) begin
            i_valid = 1'b1;
            i_mode  = 2'b01;
            i_data  = 4'hC;
            tick();
        end
        check("rst_pre_valid", 32'(o_valid_2), 32'd1);
        check("rst_pre_data",  32'(o_data_2),  32'h8);
        #3;
        rst     = 1'b1;
        i_valid = 1'b0;
        #1;
        check("rst_async_valid", 32'(o_valid_2), 32'd0);
        check("rst_async_data",  32'(o_data_2),  32'd0);
        check("rst_async_mode",  32'(o_mode_2),  32'd0);
        #2;
        rst = 1'b0;
        tick();
        check("rst_flush_0", 32'(o_valid_2), 32'd0);
        tick();
        check("rst_flush_1", 32'(o_valid_2), 32'd0);
        send_one("post_rst_inc", 2'b10, 4'b0011, 4'b0010, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_gray_codec

`default_nettype wire
